// File: rtl/icache_fetch.sv
// rtl/icache_fetch.sv - Direct-mapped read-only instruction cache between pc and instruction memory
//
// Ports:
//   CLK           clock, all state changes on posedge
//   RESET         synchronous active-high reset
//   PC            fetch byte address
//   INSTRUCTION   fetched word (0 while stalled or in reset)
//   BUSYWAIT      1 = instruction not ready, CPU stalls
//   mem_read      block read request to instruction memory
//   mem_address   block address {tag,index} (0 when mem_read=0)
//   mem_readdata  128-bit refill block, word w at bits [32w+31:32w]
//   mem_busywait  1 = memory still busy with the current read
module icache_fetch #(
    parameter int ADDR_BITS  = 10,
    parameter int INDEX_BITS = 3
) (
    input  logic                 CLK,
    input  logic                 RESET,
    input  logic [31:0]          PC,
    output logic [31:0]          INSTRUCTION,
    output logic                 BUSYWAIT,
    output logic                 mem_read,
    output logic [ADDR_BITS-5:0] mem_address,
    input  logic [127:0]         mem_readdata,
    input  logic                 mem_busywait
);

    localparam int TAG_BITS = ADDR_BITS - 4 - INDEX_BITS;
    localparam int MB       = ADDR_BITS - 4;
    localparam int LINES    = 1 << INDEX_BITS;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        MEM_READ = 2'd1,
        UPDATE   = 2'd2
    } state_t;

    state_t state, next_state;

    logic [1:0]            word;
    logic [INDEX_BITS-1:0] index;
    logic [TAG_BITS-1:0]   tag;
    logic                  hit;

    // High PC bits alias and the byte offset is irrelevant for word fetches.
    logic unused_pc;
    assign unused_pc = ^{PC[31:ADDR_BITS], PC[1:0]};

    assign word  = PC[3:2];
    assign index = PC[3+INDEX_BITS:4];
    assign tag   = PC[ADDR_BITS-1:4+INDEX_BITS];

    logic [LINES-1:0]    valid;
    logic [TAG_BITS-1:0] tag_array  [LINES];
    logic [127:0]        data_array [LINES];

    // Block address captured on a miss; the refill uses it even if PC moves.
    logic [MB-1:0]         lat_addr;
    logic [INDEX_BITS-1:0] lat_index;
    logic [TAG_BITS-1:0]   lat_tag;

    assign lat_index = lat_addr[INDEX_BITS-1:0];
    assign lat_tag   = lat_addr[MB-1:INDEX_BITS];

    assign hit = valid[index] && (tag_array[index] == tag);

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state    <= IDLE;
            valid    <= '0;
            lat_addr <= '0;
        end else begin
            state <= next_state;
            if (state == IDLE && !hit) begin
                lat_addr <= {tag, index};
            end
            if (state == UPDATE) begin
                valid[lat_index] <= 1'b1;
            end
        end
    end

    // Tag and data storage need no reset; valid bits alone qualify them.
    always_ff @(posedge CLK) begin
        if (!RESET && state == UPDATE) begin
            tag_array[lat_index]  <= lat_tag;
            data_array[lat_index] <= mem_readdata;
        end
    end

    always_comb begin
        next_state  = state;
        BUSYWAIT    = 1'b0;
        mem_read    = 1'b0;
        mem_address = '0;
        INSTRUCTION = 32'h0;
        case (state)
            IDLE: begin
                if (hit) begin
                    INSTRUCTION = data_array[index][{word, 5'b0} +: 32];
                end else begin
                    BUSYWAIT   = 1'b1;
                    next_state = MEM_READ;
                end
            end
            MEM_READ: begin
                mem_read    = 1'b1;
                mem_address = lat_addr;
                BUSYWAIT    = 1'b1;
                if (!mem_busywait) begin
                    next_state = UPDATE;
                end
            end
            UPDATE: begin
                BUSYWAIT   = 1'b1;
                next_state = IDLE;
            end
            default: begin
                next_state = IDLE;
            end
        endcase
        // Reset silences every output and abandons any in-flight read.
        if (RESET) begin
            BUSYWAIT    = 1'b0;
            mem_read    = 1'b0;
            mem_address = '0;
            INSTRUCTION = 32'h0;
        end
    end

endmodule

// File: tb/tb_icache_fetch.sv
// tb/tb_icache_fetch.sv - Directed self-checking bench for icache_fetch
module tb_icache_fetch;

    logic         CLK = 1'b0;
    logic         RESET;
    logic [31:0]  PC;
    logic [31:0]  INSTRUCTION;
    logic         BUSYWAIT;
    logic         mem_read;
    logic [5:0]   mem_address;
    logic [127:0] mem_readdata;
    logic         mem_busywait;

    int errors = 0;
    int checks = 0;

    localparam int LAT = 5;

    icache_fetch dut (
        .CLK          (CLK),
        .RESET        (RESET),
        .PC           (PC),
        .INSTRUCTION  (INSTRUCTION),
        .BUSYWAIT     (BUSYWAIT),
        .mem_read     (mem_read),
        .mem_address  (mem_address),
        .mem_readdata (mem_readdata),
        .mem_busywait (mem_busywait)
    );

    always #5 CLK = ~CLK;

    function automatic logic [31:0] wrd(input logic [5:0] a, input int w);
        return 32'hC0DE_0000 | (32'(a) << 4) | 32'(w);
    endfunction

    function automatic logic [127:0] blk(input logic [5:0] a);
        return {wrd(a, 3), wrd(a, 2), wrd(a, 1), wrd(a, 0)};
    endfunction

    // Slow memory: busy for LAT-1 cycles of a request, ready on the LAT-th;
    // the block is registered when ready and held afterwards.
    int mem_cnt = 0;
    assign mem_busywait = mem_read && (mem_cnt < LAT - 1);

    always @(posedge CLK) begin
        if (!mem_read) begin
            mem_cnt <= 0;
        end else begin
            mem_cnt <= mem_cnt + 1;
            if (mem_cnt == LAT - 1) mem_readdata <= blk(mem_address);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    // Counts stalled cycles until BUSYWAIT drops, noting the first and last
    // requested block and any nonzero address seen without mem_read.
    task automatic count_busy(output int n, output logic [5:0] first_a,
                              output logic [5:0] last_a, output logic stray);
        bit seen = 0;
        n = 0;
        first_a = '0;
        last_a = '0;
        stray = 1'b0;
        for (int i = 0; i < 60; i++) begin
            @(negedge CLK);
            if (BUSYWAIT !== 1'b1) return;
            if (mem_read === 1'b1) begin
                if (!seen) first_a = mem_address;
                seen = 1;
                last_a = mem_address;
            end else if (mem_address !== 6'd0) begin
                stray = 1'b1;
            end
            n++;
            step();
        end
        n = -1;
    endtask

    task automatic do_reset();
        step();
        RESET = 1'b1;
        step();
        step();
        RESET = 1'b0;
    endtask

    task automatic test_reset();
        RESET = 1'b1;
        PC = 32'h0;
        step();
        step();
        @(negedge CLK);
        checks++;
        if (BUSYWAIT !== 1'b0 || mem_read !== 1'b0 || INSTRUCTION !== 32'h0) begin
            errors++;
            $display("FAIL reset_outputs: busywait=%b mem_read=%b instr=%h, want 0 0 0",
                     BUSYWAIT, mem_read, INSTRUCTION);
        end
        step();
        RESET = 1'b0;
    endtask

    task automatic test_first_miss();
        int n;
        logic [5:0] fa, la;
        logic stray;
        count_busy(n, fa, la, stray);
        checks++;
        if (n !== 7) begin
            errors++;
            $display("FAIL miss_latency: %0d cycles, want 7", n);
        end
        checks++;
        if (fa !== 6'd0 || stray !== 1'b0) begin
            errors++;
            $display("FAIL miss_addr: addr=%0d stray=%b, want 0 0", fa, stray);
        end
        checks++;
        if (BUSYWAIT !== 1'b0 || INSTRUCTION !== wrd(6'd0, 0)) begin
            errors++;
            $display("FAIL miss_data: busywait=%b instr=%h, want 0 %h",
                     BUSYWAIT, INSTRUCTION, wrd(6'd0, 0));
        end
    endtask

    task automatic test_hits();
        for (int w = 1; w < 4; w++) begin
            step();
            PC = 32'(w * 4);
            @(negedge CLK);
            checks++;
            if (BUSYWAIT !== 1'b0 || mem_read !== 1'b0 || INSTRUCTION !== wrd(6'd0, w)) begin
                errors++;
                $display("FAIL hit_word%0d: busywait=%b mem_read=%b instr=%h, want 0 0 %h",
                         w, BUSYWAIT, mem_read, INSTRUCTION, wrd(6'd0, w));
            end
        end
    endtask

    task automatic test_evict();
        logic [31:0] pcs [3] = '{32'h000, 32'h080, 32'h000};
        logic [5:0]  exp [3] = '{6'd0, 6'd8, 6'd0};
        int n;
        logic [5:0] fa, la;
        logic stray;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            PC = pcs[i];
            count_busy(n, fa, la, stray);
            checks++;
            if (n !== 7 || fa !== exp[i] || INSTRUCTION !== wrd(exp[i], 0)) begin
                errors++;
                $display("FAIL evict%0d: cycles=%0d addr=%0d instr=%h, want 7 %0d %h",
                         i, n, fa, INSTRUCTION, exp[i], wrd(exp[i], 0));
            end
            step();
        end
    endtask

    task automatic test_pc_change_mid_refill();
        int n;
        logic [5:0] fa, la;
        logic stray;
        PC = 32'h010;
        @(negedge CLK);
        checks++;
        if (BUSYWAIT !== 1'b1) begin
            errors++;
            $display("FAIL midref_detect: busywait=%b, want 1", BUSYWAIT);
        end
        step();
        PC = 32'h020;
        count_busy(n, fa, la, stray);
        checks++;
        if (n !== 13 || fa !== 6'd1 || la !== 6'd2) begin
            errors++;
            $display("FAIL midref_seq: cycles=%0d first=%0d last=%0d, want 13 1 2", n, fa, la);
        end
        checks++;
        if (INSTRUCTION !== wrd(6'd2, 0)) begin
            errors++;
            $display("FAIL midref_new: instr=%h, want %h", INSTRUCTION, wrd(6'd2, 0));
        end
        step();
        PC = 32'h010;
        @(negedge CLK);
        checks++;
        if (BUSYWAIT !== 1'b0 || INSTRUCTION !== wrd(6'd1, 0)) begin
            errors++;
            $display("FAIL midref_old: busywait=%b instr=%h, want 0 %h",
                     BUSYWAIT, INSTRUCTION, wrd(6'd1, 0));
        end
    endtask

    task automatic test_reset_mid_read();
        int n;
        logic [5:0] fa, la;
        logic stray;
        step();
        PC = 32'h030;
        step();
        @(negedge CLK);
        checks++;
        if (mem_read !== 1'b1 || mem_address !== 6'd3) begin
            errors++;
            $display("FAIL rst_mid_pre: mem_read=%b addr=%0d, want 1 3", mem_read, mem_address);
        end
        step();
        RESET = 1'b1;
        @(negedge CLK);
        checks++;
        if (mem_read !== 1'b0 || BUSYWAIT !== 1'b0 || INSTRUCTION !== 32'h0) begin
            errors++;
            $display("FAIL rst_mid_out: mem_read=%b busywait=%b instr=%h, want 0 0 0",
                     mem_read, BUSYWAIT, INSTRUCTION);
        end
        step();
        RESET = 1'b0;
        PC = 32'h0;
        count_busy(n, fa, la, stray);
        checks++;
        if (n !== 7 || fa !== 6'd0 || INSTRUCTION !== wrd(6'd0, 0)) begin
            errors++;
            $display("FAIL rst_mid_refetch: cycles=%0d addr=%0d instr=%h, want 7 0 %h",
                     n, fa, INSTRUCTION, wrd(6'd0, 0));
        end
    endtask

    task automatic test_alias();
        int n;
        logic [5:0] fa, la;
        logic stray;
        step();
        PC = 32'h3FC;
        count_busy(n, fa, la, stray);
        checks++;
        if (n !== 7 || fa !== 6'd63 || INSTRUCTION !== wrd(6'd63, 3)) begin
            errors++;
            $display("FAIL top_word: cycles=%0d addr=%0d instr=%h, want 7 63 %h",
                     n, fa, INSTRUCTION, wrd(6'd63, 3));
        end
        step();
        PC = 32'h400;
        @(negedge CLK);
        checks++;
        if (BUSYWAIT !== 1'b0 || INSTRUCTION !== wrd(6'd0, 0)) begin
            errors++;
            $display("FAIL alias_400: busywait=%b instr=%h, want 0 %h",
                     BUSYWAIT, INSTRUCTION, wrd(6'd0, 0));
        end
        step();
        PC = 32'hFFFF_F004;
        @(negedge CLK);
        checks++;
        if (BUSYWAIT !== 1'b0 || INSTRUCTION !== wrd(6'd0, 1)) begin
            errors++;
            $display("FAIL alias_high: busywait=%b instr=%h, want 0 %h",
                     BUSYWAIT, INSTRUCTION, wrd(6'd0, 1));
        end
    endtask

    initial begin
        RESET = 1'b1;
        PC = 32'h0;
        mem_readdata = '0;
        test_reset();
        test_first_miss();
        test_hits();
        test_evict();
        test_pc_change_mid_refill();
        test_reset_mid_read();
        test_alias();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
